// File: rtl/cpu_ctrl_pkg.sv
// Shared state, opcode and ALU encodings for the hardwired control sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

    typedef enum logic [2:0] {
        C_NOP, C_ALU2, C_ALU1, C_MULDIV, C_HALT
    } iclass_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Zero is reserved as the idle ALU select.
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_MUL  = 5'b00011;
    localparam logic [4:0] ALU_DIV  = 5'b00100;
    localparam logic [4:0] ALU_SHR  = 5'b00101;
    localparam logic [4:0] ALU_SHRA = 5'b00110;
    localparam logic [4:0] ALU_SHL  = 5'b00111;
    localparam logic [4:0] ALU_ROR  = 5'b01000;
    localparam logic [4:0] ALU_ROL  = 5'b01001;
    localparam logic [4:0] ALU_AND  = 5'b01010;
    localparam logic [4:0] ALU_OR   = 5'b01011;
    localparam logic [4:0] ALU_NEG  = 5'b01100;
    localparam logic [4:0] ALU_NOT  = 5'b01101;

    typedef struct packed {
        logic pc_out;
        logic zlo_out;
        logic zhi_out;
        logic mdr_out;
        logic pc_enable;
        logic pc_increment;
        logic mar_enable;
        logic mdr_enable;
        logic read;
        logic ir_enable;
        logic y_enable;
        logic z_enable;
        logic lo_enable;
        logic hi_enable;
        logic halted;
        logic instr_done;
    } strobe_t;

    function automatic logic [4:0] alu_sel(input logic [4:0] opcode);
        case (opcode)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_SHR:  return ALU_SHR;
            OP_SHRA: return ALU_SHRA;
            OP_SHL:  return ALU_SHL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic iclass_t instr_class(input logic [4:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: return C_ALU2;
            OP_NEG, OP_NOT:                  return C_ALU1;
            OP_MUL, OP_DIV:                  return C_MULDIV;
            OP_HALT:                         return C_HALT;
            default:                         return C_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_sequencer_reg_select_decoder.sv
// One-hot general register select; out-of-range indexes select nothing.
module reg_select_decoder #(
    parameter int NREG = 16,
    parameter int FW   = 4
) (
    input  logic [FW-1:0]   field,
    input  logic            en,
    output logic [NREG-1:0] sel
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREG; i++) begin
            sel[i] = en && (int'(field) == i);
        end
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute sequencer driving the datapath control strobes.
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            pc_out,
    output logic            zlo_out,
    output logic            zhi_out,
    output logic            mdr_out,
    output logic            pc_enable,
    output logic            pc_increment,
    output logic            mar_enable,
    output logic            mdr_enable,
    output logic            read,
    output logic            ir_enable,
    output logic            y_enable,
    output logic            z_enable,
    output logic            lo_enable,
    output logic            hi_enable,
    output logic [OPW-1:0]  op_code,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic            halted,
    output logic            instr_done
);

    state_t          state, state_n;
    iclass_t         cls;
    strobe_t         strb_d, strb_q;
    logic [OPW-1:0]  op_d, op_q;
    logic [NREG-1:0] reg_in_d, reg_in_q;
    logic [NREG-1:0] reg_out_d, reg_out_q;
    logic            in_en, out_en;
    logic [3:0]      out_sel;
    logic            unused_ir;

    assign cls       = instr_class(ir[31:27]);
    assign unused_ir = ^ir[14:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= T0;
            strb_q    <= '0;
            op_q      <= '0;
            reg_in_q  <= '0;
            reg_out_q <= '0;
        end else begin
            state     <= state_n;
            strb_q    <= strb_d;
            op_q      <= op_d;
            reg_in_q  <= reg_in_d;
            reg_out_q <= reg_out_d;
        end
    end

    always_comb begin
        state_n = state;
        strb_d  = '0;
        op_d    = '0;
        in_en   = 1'b0;
        out_en  = 1'b0;
        out_sel = ir[22:19];
        unique case (state)
            T0: begin
                strb_d.pc_out       = 1'b1;
                strb_d.mar_enable   = 1'b1;
                strb_d.pc_increment = 1'b1;
                strb_d.z_enable     = 1'b1;
                state_n = T1;
            end
            T1: begin
                strb_d.zlo_out    = 1'b1;
                strb_d.read       = 1'b1;
                strb_d.mdr_enable = 1'b1;
                strb_d.pc_enable  = mem_ready;
                if (mem_ready) state_n = T2;
            end
            T2: begin
                strb_d.mdr_out   = 1'b1;
                strb_d.ir_enable = 1'b1;
                state_n = T3;
            end
            T3: begin
                out_en            = 1'b1;
                strb_d.y_enable   = 1'b1;
                strb_d.instr_done = (cls == C_NOP);
                if (cls == C_HALT) state_n = HALT;
                else if (cls == C_NOP) state_n = T0;
                else state_n = T4;
            end
            T4: begin
                out_en          = 1'b1;
                out_sel         = (cls == C_ALU1) ? ir[22:19] : ir[18:15];
                op_d            = OPW'(alu_sel(ir[31:27]));
                strb_d.z_enable = 1'b1;
                state_n = T5;
            end
            T5: begin
                op_d           = OPW'(alu_sel(ir[31:27]));
                strb_d.zlo_out = 1'b1;
                if (cls == C_MULDIV) begin
                    strb_d.lo_enable = 1'b1;
                    state_n = T6;
                end else begin
                    in_en             = 1'b1;
                    strb_d.instr_done = 1'b1;
                    state_n = T0;
                end
            end
            T6: begin
                op_d              = OPW'(alu_sel(ir[31:27]));
                strb_d.zhi_out    = 1'b1;
                strb_d.hi_enable  = 1'b1;
                strb_d.instr_done = 1'b1;
                state_n = T0;
            end
            HALT: begin
                strb_d.halted = 1'b1;
            end
        endcase
    end

    reg_select_decoder #(.NREG(NREG), .FW(4)) u_reg_in (
        .field (ir[26:23]),
        .en    (in_en),
        .sel   (reg_in_d)
    );

    reg_select_decoder #(.NREG(NREG), .FW(4)) u_reg_out (
        .field (out_sel),
        .en    (out_en),
        .sel   (reg_out_d)
    );

    assign pc_out       = strb_q.pc_out;
    assign zlo_out      = strb_q.zlo_out;
    assign zhi_out      = strb_q.zhi_out;
    assign mdr_out      = strb_q.mdr_out;
    assign pc_enable    = strb_q.pc_enable;
    assign pc_increment = strb_q.pc_increment;
    assign mar_enable   = strb_q.mar_enable;
    assign mdr_enable   = strb_q.mdr_enable;
    assign read         = strb_q.read;
    assign ir_enable    = strb_q.ir_enable;
    assign y_enable     = strb_q.y_enable;
    assign z_enable     = strb_q.z_enable;
    assign lo_enable    = strb_q.lo_enable;
    assign hi_enable    = strb_q.hi_enable;
    assign halted       = strb_q.halted;
    assign instr_done   = strb_q.instr_done;
    assign op_code      = op_q;
    assign reg_in       = reg_in_q;
    assign reg_out      = reg_out_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboarded directed and random bench for alu_control_sequencer.
module tb_alu_control_sequencer;

    localparam int NREG = 16;
    localparam int OPW  = 5;

    logic            clk = 1'b0;
    logic            clr;
    logic            mem_ready;
    logic [31:0]     ir;
    logic            pc_out, zlo_out, zhi_out, mdr_out;
    logic            pc_enable, pc_increment, mar_enable, mdr_enable;
    logic            read, ir_enable, y_enable, z_enable;
    logic            lo_enable, hi_enable, halted, instr_done;
    logic [OPW-1:0]  op_code;
    logic [NREG-1:0] reg_in, reg_out;

    alu_control_sequencer #(.NREG(NREG), .OPW(OPW)) dut (
        .clk          (clk),
        .clr          (clr),
        .ir           (ir),
        .mem_ready    (mem_ready),
        .pc_out       (pc_out),
        .zlo_out      (zlo_out),
        .zhi_out      (zhi_out),
        .mdr_out      (mdr_out),
        .pc_enable    (pc_enable),
        .pc_increment (pc_increment),
        .mar_enable   (mar_enable),
        .mdr_enable   (mdr_enable),
        .read         (read),
        .ir_enable    (ir_enable),
        .y_enable     (y_enable),
        .z_enable     (z_enable),
        .lo_enable    (lo_enable),
        .hi_enable    (hi_enable),
        .op_code      (op_code),
        .reg_in       (reg_in),
        .reg_out      (reg_out),
        .halted       (halted),
        .instr_done   (instr_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] s;
        logic [4:0]  op;
        logic [15:0] rin;
        logic [15:0] rout;
    } frame_t;

    typedef struct {
        frame_t      f;
        logic        mr;
        logic [31:0] w;
        string       tag;
    } entry_t;

    localparam logic [15:0] S_PCO   = 16'h8000;
    localparam logic [15:0] S_ZLO   = 16'h4000;
    localparam logic [15:0] S_ZHI   = 16'h2000;
    localparam logic [15:0] S_MDRO  = 16'h1000;
    localparam logic [15:0] S_PCEN  = 16'h0800;
    localparam logic [15:0] S_PCINC = 16'h0400;
    localparam logic [15:0] S_MAR   = 16'h0200;
    localparam logic [15:0] S_MDREN = 16'h0100;
    localparam logic [15:0] S_RD    = 16'h0080;
    localparam logic [15:0] S_IREN  = 16'h0040;
    localparam logic [15:0] S_Y     = 16'h0020;
    localparam logic [15:0] S_Z     = 16'h0010;
    localparam logic [15:0] S_LO    = 16'h0008;
    localparam logic [15:0] S_HI    = 16'h0004;
    localparam logic [15:0] S_HALT  = 16'h0002;
    localparam logic [15:0] S_DONE  = 16'h0001;

    frame_t obs;
    assign obs = {{pc_out, zlo_out, zhi_out, mdr_out, pc_enable,
                   pc_increment, mar_enable, mdr_enable, read,
                   ir_enable, y_enable, z_enable, lo_enable,
                   hi_enable, halted, instr_done},
                  op_code, reg_in, reg_out};

    entry_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    function automatic logic [15:0] oh(input logic [3:0] f);
        logic [15:0] one;
        one = 16'h0001;
        return one << f;
    endfunction

    function automatic logic [4:0] exp_alu(input logic [4:0] opc);
        case (opc)
            5'b00011: return 5'b00001;
            5'b00100: return 5'b00010;
            5'b00101: return 5'b01010;
            5'b00110: return 5'b01011;
            5'b00111: return 5'b01000;
            5'b01000: return 5'b01001;
            5'b01001: return 5'b00101;
            5'b01010: return 5'b00110;
            5'b01011: return 5'b00111;
            5'b01111: return 5'b00011;
            5'b10000: return 5'b00100;
            5'b10001: return 5'b01100;
            5'b10010: return 5'b01101;
            default:  return 5'b00000;
        endcase
    endfunction

    // 0 nop-class, 1 two-operand, 2 unary, 3 mul/div, 4 halt
    function automatic int kind(input logic [4:0] opc);
        if (opc >= 5'b00011 && opc <= 5'b01011) return 1;
        if (opc == 5'b10001 || opc == 5'b10010) return 2;
        if (opc == 5'b01111 || opc == 5'b10000) return 3;
        if (opc == 5'b11011) return 4;
        return 0;
    endfunction

    function automatic frame_t fr(input logic [15:0] s, input logic [4:0] op,
                                  input logic [15:0] rin, input logic [15:0] rout);
        return {s, op, rin, rout};
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'd0};
    endfunction

    task automatic add(input frame_t f, input logic mr, input logic [31:0] w,
                       input string tag);
        entry_t e;
        e.f = f;
        e.mr = mr;
        e.w = w;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] w, input int nwait, input int nhalt);
        logic [4:0] opc, a;
        logic [3:0] ra, rb, rc;
        int k;
        opc = w[31:27];
        ra = w[26:23];
        rb = w[22:19];
        rc = w[18:15];
        k = kind(opc);
        a = exp_alu(opc);
        add(fr(S_PCO | S_MAR | S_PCINC | S_Z, 5'd0, 16'd0, 16'd0), 1'b1, w, "T0");
        for (int i = 0; i < nwait; i++)
            add(fr(S_ZLO | S_RD | S_MDREN, 5'd0, 16'd0, 16'd0), 1'b0, w, "T1wait");
        add(fr(S_ZLO | S_RD | S_MDREN | S_PCEN, 5'd0, 16'd0, 16'd0), 1'b1, w, "T1");
        add(fr(S_MDRO | S_IREN, 5'd0, 16'd0, 16'd0), 1'b1, w, "T2");
        add(fr(S_Y | ((k == 0) ? S_DONE : 16'h0000), 5'd0, 16'd0, oh(rb)),
            1'b1, w, "T3");
        if (k == 4) begin
            for (int i = 0; i < nhalt; i++)
                add(fr(S_HALT, 5'd0, 16'd0, 16'd0), 1'b1, w, "HALT");
        end else if (k != 0) begin
            add(fr(S_Z, a, 16'd0, oh((k == 2) ? rb : rc)), 1'b1, w, "T4");
            if (k == 3) begin
                add(fr(S_ZLO | S_LO, a, 16'd0, 16'd0), 1'b1, w, "T5md");
                add(fr(S_ZHI | S_HI | S_DONE, a, 16'd0, 16'd0), 1'b1, w, "T6");
            end else begin
                add(fr(S_ZLO | S_DONE, a, oh(ra), 16'd0), 1'b1, w, "T5");
            end
        end
    endtask

    task automatic check(input string tag, input frame_t exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_check();
        int n;
        n = $countones({pc_out, zlo_out, zhi_out, mdr_out, reg_out});
        compared++;
        assert (n <= 1) else begin
            mismatched++;
            $error("FAIL bus_drivers: observed %0d, expected <=1", n);
        end
        compared++;
        assert ($onehot0(reg_in)) else begin
            mismatched++;
            $error("FAIL reg_in_onehot: observed %h, expected one-hot or zero", reg_in);
        end
    endtask

    task automatic step();
        entry_t e;
        e = sb.pop_front();
        mem_ready = e.mr;
        ir = e.w;
        @(posedge clk);
        #1;
        check(e.tag, e.f);
        bus_check();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n && sb.size() > 0; i++) step();
    endtask

    task automatic drain();
        while (sb.size() != 0) step();
    endtask

    task automatic clr_tick();
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr", '0);
        bus_check();
    endtask

    initial begin
        logic [4:0]  ops [15];
        logic [31:0] w;
        ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                5'b10000, 5'b10001, 5'b10010, 5'b11010, 5'b11111};
        clr = 1'b1;
        mem_ready = 1'b1;
        ir = '0;
        clr_tick();
        clr_tick();
        clr = 1'b0;

        // Abort an instruction once its T4 step is on the outputs.
        issue(mk(5'b00101, 4'd4, 4'd3, 4'd7), 0, 0);
        run_n(5);
        clr_tick();
        clr_tick();
        clr = 1'b0;
        sb.delete();

        issue(mk(5'b00101, 4'd4, 4'd3, 4'd7), 0, 0);
        drain();
        issue(mk(5'b00011, 4'd9, 4'd10, 4'd11), 3, 0);
        drain();
        issue(mk(5'b01111, 4'd0, 4'd1, 4'd2), 0, 0);
        drain();
        issue(mk(5'b10000, 4'd5, 4'd14, 4'd15), 1, 0);
        drain();
        issue(mk(5'b10001, 4'd0, 4'd12, 4'd6), 0, 0);
        drain();
        issue(mk(5'b10010, 4'd15, 4'd0, 4'd9), 2, 0);
        drain();

        issue(mk(5'b11011, 4'd1, 4'd2, 4'd3), 0, 20);
        drain();
        clr_tick();
        clr = 1'b0;
        issue(mk(5'b11111, 4'd1, 4'd2, 4'd3), 0, 0);
        drain();

        for (int i = 0; i < 200; i++) begin
            w = $urandom();
            w[31:27] = ops[$urandom_range(0, 14)];
            issue(w, $urandom_range(0, 2), 0);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
